// File: rtl/shift_seq.sv
// Iterative logical right shifter: one bit position per clock, valid/ready on both sides.
// Optional macro SHIFT_SEQ_EARLY_EXIT_EN finishes early once the register reaches zero.
module shift_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  // Compare wide enough that neither the amount nor WIDTH is truncated.
  localparam int unsigned CMP_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CMP_W-1:0] amt_ext;
  logic [CNT_W-1:0] n_load;
  logic             accept;
  logic             load_done;
  logic             skip_shift;
  logic             shift_done;

  assign amt_ext = CMP_W'(in_amt);
  assign n_load  = (amt_ext >= CMP_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(amt_ext);
  assign accept  = in_valid && in_ready;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  assign load_done  = (n_load == '0) || (in_data == '0);
  assign skip_shift = (sreg_q == '0);
`else
  assign load_done  = (n_load == '0);
  assign skip_shift = 1'b0;
`endif
  assign shift_done = skip_shift || (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = load_done ? StDone : StShift;
      StShift: if (shift_done) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: shift register and remaining-shift counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sreg_q <= in_data;
            cnt_q  <= n_load;
          end
        end
        StShift: begin
          if (!skip_shift) begin
            sreg_q <= sreg_q >> 1;
            cnt_q  <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_data  = sreg_q;
  end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed table, reset abort, and randomized operations
// against a behavioural latency/result model.
module tb_shift_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] amt;
    int         hold;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural latency: cycle (after accept) in which out_valid first rises.
  function automatic int model_lat(input logic [7:0] d, input int a);
    int n;
    n = (a < int'(WIDTH)) ? a : int'(WIDTH);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    begin
      int k;
      if (d == 0) return 1;
      k = 0;
      for (int i = 0; i < int'(WIDTH); i++) if (d[i]) k = i + 1;
      // k shifts empty the register, one more cycle notices it is zero
      if (k < n) return k + 2;
    end
`endif
    return n + 1;
  endfunction

  // One complete operation: accept, wait for result, apply hold cycles of backpressure
  // while presenting junk operands, then complete the handshake.
  task automatic do_op(input logic [7:0] d, input logic [7:0] a, input int hold,
                       input logic [7:0] exp_d, input int exp_lat, input string tag);
    int cyc;
    bit seen;
    logic [7:0] held;
    check({tag, " ready_before_accept"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    seen = 1'b0;
    cyc  = 1;
    // Operands presented outside IDLE must be ignored
    in_data = 8'($urandom);
    in_amt  = 8'($urandom);
    while (!seen && cyc <= 3 * int'(WIDTH)) begin
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      check({tag, " timeout"}, 32'(cyc), 32'(exp_lat));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      return;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " data"}, out_data, exp_d);
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold_valid"}, out_valid, 1'b1);
      check({tag, " hold_data"}, out_data, held);
      check({tag, " hold_busy"}, busy, 1'b1);
      check({tag, " hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " done_valid_drop"}, out_valid, 1'b0);
    check({tag, " back_idle"}, {busy, in_ready}, 2'b01);
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    vecs.push_back('{8'hB6, 8'd3,   0, 8'h16, 4});
    vecs.push_back('{8'hA5, 8'd0,   0, 8'hA5, 1});
    vecs.push_back('{8'hFF, 8'd8,   0, 8'h00, 9});
    vecs.push_back('{8'hFF, 8'd200, 0, 8'h00, 9});
    vecs.push_back('{8'h80, 8'd7,   5, 8'h01, 8});
    vecs.push_back('{8'hFF, 8'd255, 2, 8'h00, 9});
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    vecs.push_back('{8'h01, 8'd7,   0, 8'h00, 3});
    vecs.push_back('{8'h00, 8'd5,   0, 8'h00, 1});
`else
    vecs.push_back('{8'h01, 8'd7,   0, 8'h00, 8});
    vecs.push_back('{8'h00, 8'd5,   0, 8'h00, 6});
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_amt = '0;
    out_ready = 1'b0;
    @(negedge clk);
    check("reset_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("reset_state", {out_valid, busy, out_data}, 10'h000);
    check("reset_in_ready_still_low", in_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", in_ready, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_op(v.data, v.amt, v.hold, v.exp_data, v.exp_lat, $sformatf("vec%0d", i));
    end

    // Reset in cycle 2 of an amount-5 operation aborts it
    in_valid = 1'b1;
    in_data = 8'hF0;
    in_amt = 8'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy_c1", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {busy, out_valid, out_data}, 10'h000);
    for (int c = 0; c < 8; c++) begin
      check("abort_no_valid", out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    do_op(8'h40, 8'd2, 0, 8'h10, 3, "after_abort");

    // Randomized operations against the model
    for (int i = 0; i < 150; i++) begin
      logic [7:0] d;
      logic [7:0] a;
      int sel;
      sel = int'($urandom_range(0, 3));
      d = (sel == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, WIDTH)) : 8'($urandom);
      do_op(d, a, int'($urandom_range(0, 3)), 8'(32'(d) >> a), model_lat(d, int'(a)),
            $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Iterative logical right shifter with valid/ready handshakes on both sides. It sits directly downstream of the pin-level operand decode: it consumes a (data, amount) pair and produces `data >> amount` one bit position per clock. It trades the area of a combinational barrel shifter for multi-cycle latency, and it registers the result toward the output pins.

## Interface
Parameters:
- `WIDTH`, 8: data width in bits.
- `AMT_W`, 8: width of the shift-amount operand.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair is valid.
- `in_ready` out 1: block accepts a new operand pair.
- `in_data` in `WIDTH`: value to be shifted.
- `in_amt` in `AMT_W`: shift amount, unsigned.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out `WIDTH`: shifted result.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- `in_ready` = (state==IDLE) && !`rst`. `out_valid` = (state==DONE). `busy` = (state!=IDLE).
- IDLE, accept on `in_valid && in_ready`:
  - Load `in_data` into the shift register.
  - Load cnt = n = min(`in_amt`, `WIDTH`). The comparison is done at full `AMT_W` width, with no truncation.
  - Go to DONE if n==0, otherwise go to SHIFT.
- SHIFT, each cycle: shift the register right by 1 with zero fill and decrement cnt. Go to DONE on the edge where cnt goes from 1 to 0.
- DONE:
  - `out_data` is the register value, held stable until `out_ready`.
  - On `out_valid && out_ready`, return to IDLE.
  - `in_valid` is ignored outside IDLE. No overlap of operations.
- Arithmetic: the result equals `in_data >> in_amt` for every `in_amt` value. An `in_amt` ≥ `WIDTH` yields 0.
- `out_data` outside DONE equals the internal register. Its value there is don't-care, but it must not be X after reset.

## Timing
- Reset values: state IDLE, register 0, cnt 0, `out_valid`=0, `out_data`=0, `busy`=0, `in_ready`=0 while `rst` is high.
- `in_ready` becomes 1 in the first cycle after `rst` is sampled low.
- Cycle numbering: the cycle following the accept edge is cycle 1.
- Latency: `out_valid` first rises in cycle n+1.
  - n=0 gives cycle 1.
  - n=`WIDTH` gives cycle `WIDTH`+1.
- Minimum spacing between accepts is n+2 cycles: the accept cycle, n SHIFT cycles, one DONE cycle with `out_ready`=1. The next accept is possible in the cycle after DONE.
- Backpressure: `out_valid` and `out_data` stay constant while `out_ready`=0, indefinitely.
- Reset mid-operation (SHIFT or DONE): on the next edge, the operation is aborted and all reset values are applied. No `out_valid` is produced for the aborted operand.
- `rst` has priority over all handshakes on the same edge.

## Configuration
- Macro `SHIFT_SEQ_EARLY_EXIT_EN`.
- Defined:
  - At accept, if `in_data`==0, go directly to DONE.
  - In SHIFT, if the register is 0 at the start of the cycle, go to DONE on that edge without shifting.
  - The result is unchanged; only latency shrinks.
- Undefined:
  - No zero detection. Latency is exactly n+1 for all data.

## Test plan
- `in_data`=0xB6, `in_amt`=3, `out_ready`=1 → `out_data`=0x16; `out_valid` rises in cycle 4 for exactly 1 cycle; `in_ready` is 1 again in cycle 5.
- `in_data`=0xA5, `in_amt`=0 → `out_data`=0xA5 with `out_valid` in cycle 1.
- `in_data`=0xFF, `in_amt`=8, then `in_amt`=200 → `out_data`=0x00 in cycle 9 for both runs (cnt saturates at 8).
- `in_data`=0x80, `in_amt`=7; hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 with other operands → `out_data`=0x01 held stable, `in_ready`=0, `busy`=1, no new operand captured; completion occurs on the first `out_ready`=1.
- Assert `rst` for 1 cycle in cycle 2 of an `in_amt`=5 operation → `busy`=0 and `out_valid`=0 next cycle; `out_valid` never asserts for that operand; a new operand 0x40, `in_amt`=2 then yields 0x10 normally.
- `in_data`=0x01, `in_amt`=7 → `out_data`=0x00. With `SHIFT_SEQ_EARLY_EXIT_EN`, `out_valid` rises in cycle 3; without it, in cycle 8. With the macro, `in_data`=0x00, `in_amt`=5 gives `out_valid` in cycle 1.
